versatile_fifo_rd_sched: RTL and testbench

Read-side controller for the versatile async FIFO.
- Owns the FIFO read pointer, in binary for RAM addressing and Gray for the async comparator's rptr input.
- Shares the FIFO's read port among NREQ consumers using round-robin bursts.
- Runs entirely in the read-clock domain and consumes the comparator's fifo_empty flag.

---
 rtl/versatile_fifo_rd_sched.sv | 198 +++++++++++++++++++
 tb/tb_versatile_fifo_rd_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/versatile_fifo_rd_sched.sv
// ----------------------------------------------------------------------------
// versatile_fifo_rd_sched
//
// Read-side controller for the versatile async FIFO. It owns the read pointer
// and keeps it in binary (RAM address) and Gray (for the async comparator).
// It also shares the single FIFO read port among NREQ consumers. Each grant
// buys one burst of up to BURST_MAX reads. Everything runs in the read-clock
// domain and uses the comparator's fifo_empty flag.
//
// Parameters:
//   ADDR_WIDTH  FIFO address width (rd_addr / rptr width)
//   NREQ        number of consumers (2..8)
//   BURST_MAX   maximum reads per grant (1..15)
//
// Ports:
//   clk        read-domain clock
//   rst_n      asynchronous active-low reset
//   fifo_empty empty flag from comparator (rclk domain)
//   req        per-consumer read request, level
//   gnt        one-hot grant, registered; valid from GRANT until burst exit
//   rd_en      read strobe to FIFO RAM this cycle (combinational)
//   rd_addr    binary read address
//   rptr       Gray read pointer to comparator
//   rvalid     read data valid, one cycle after rd_en (RAM latency 1)
//   rvalid_id  consumer that owns the rvalid data
//   busy       high while in GRANT or BURST
//
// Build option:
//   VFIFO_RD_FIXED_PRIO_EN  when defined, arbitration is fixed priority with
//                           the lowest index winning and no last-winner state.
//                           When undefined, arbitration is round-robin.
// ----------------------------------------------------------------------------
module versatile_fifo_rd_sched #(
  parameter int ADDR_WIDTH = 4,
  parameter int NREQ       = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [ADDR_WIDTH-1:0]    rptr,
  output logic                     rvalid,
  output logic [$clog2(NREQ)-1:0]  rvalid_id,
  output logic                     busy
);

  localparam int         ID_W     = $clog2(NREQ);
  localparam logic [3:0] BEAT_MAX = 4'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BURST
  } state_e;

  state_e                  state_q,     state_d;
  logic [NREQ-1:0]         gnt_q,       gnt_d;
  logic [ID_W-1:0]         owner_q,     owner_d;
  logic [3:0]              beat_q,      beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
  logic [ADDR_WIDTH-1:0]   rptr_q,      rptr_d;
  logic                    rvalid_q,    rvalid_d;
  logic [ID_W-1:0]         rvalid_id_q, rvalid_id_d;
`ifndef VFIFO_RD_FIXED_PRIO_EN
  logic [ID_W-1:0]         last_q,      last_d;
`endif

  logic                    win_found;
  logic [ID_W-1:0]         win_idx;

  // Arbitration: choose the winner among the current requests.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef VFIFO_RD_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
`else
    // Search upward from the slot after the last winner and wrap around.
    // Because the last winner is tried last, every requester gets served
    // within NREQ grants.
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_found && req[(int'(last_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = ID_W'((int'(last_q) + i) % NREQ);
      end
    end
`endif
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every signal is given a default before the case statement, so no
    // path can leave a value unassigned and infer a latch.
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    rptr_d      = rptr_q;
    rd_en       = 1'b0;
`ifndef VFIFO_RD_FIXED_PRIO_EN
    last_d      = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && win_found) begin
          state_d = ST_GRANT;
          gnt_d   = NREQ'(1) << win_idx;
          owner_d = win_idx;
        end
      end

      ST_GRANT: begin
        state_d = ST_BURST;
        beat_d  = '0;
      end

      ST_BURST: begin
        // fifo_empty can rise within this cycle once rptr catches wptr. Gating
        // rd_en with it here prevents a read past the last word.
        rd_en = req[owner_q] & ~fifo_empty & (beat_q < BEAT_MAX);
        if (rd_en) begin
          addr_d = addr_q + 1'b1;
          rptr_d = addr_d ^ (addr_d >> 1);
          beat_d = beat_q + 4'd1;
        end
        // The burst is over for good here. If empty deasserts later, the
        // consumer must win arbitration again.
        if (!req[owner_q] || fifo_empty || (beat_d == BEAT_MAX)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
`ifndef VFIFO_RD_FIXED_PRIO_EN
          last_d  = owner_q;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    // RAM latency is one cycle: the read data and its owner appear next cycle.
    rvalid_d    = rd_en;
    rvalid_id_d = rd_en ? owner_q : rvalid_id_q;
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the clock edge no matter how the statements are
  // ordered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      rptr_q      <= '0;
      rvalid_q    <= 1'b0;
      rvalid_id_q <= '0;
`ifndef VFIFO_RD_FIXED_PRIO_EN
      // Consumer 0 comes first in round-robin order after reset.
      last_q      <= ID_W'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      rptr_q      <= rptr_d;
      rvalid_q    <= rvalid_d;
      rvalid_id_q <= rvalid_id_d;
`ifndef VFIFO_RD_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rd_addr   = addr_q;
  assign rptr      = rptr_q;
  assign rvalid    = rvalid_q;
  assign rvalid_id = rvalid_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_versatile_fifo_rd_sched.sv
// ----------------------------------------------------------------------------
// tb_versatile_fifo_rd_sched
//
// Directed bench for versatile_fifo_rd_sched (ADDR_WIDTH=4, NREQ=4,
// BURST_MAX=4). A small FIFO environment holds a binary write pointer. It
// drives fifo_empty the way the async comparator does, from the DUT's Gray
// rptr against the Gray of the write pointer. A negedge monitor records grants,
// burst lengths and rvalid traffic. Directed steps compare these records
// against hand-computed expectations.
// Build option: VFIFO_RD_FIXED_PRIO_EN changes the expected grant order in the
// last step.
// ----------------------------------------------------------------------------
module tb_versatile_fifo_rd_sched;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [3:0] rptr;
  logic       rvalid;
  logic [1:0] rvalid_id;
  logic       busy;

  logic [3:0] wptr;

  int errors = 0;
  int checks = 0;

  int grant_q[$];
  int burst_q[$];
  int rv_id_q[$];
  int addr_q[$];
  int rptr_q[$];
  int rd_cnt;
  int rv_cnt;
  int cur_burst;
  logic prev_rd_en;
  logic [3:0] prev_gnt;

  versatile_fifo_rd_sched #(
    .ADDR_WIDTH (4),
    .NREQ       (4),
    .BURST_MAX  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .req        (req),
    .gnt        (gnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rptr       (rptr),
    .rvalid     (rvalid),
    .rvalid_id  (rvalid_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: the FIFO is empty when the Gray pointers match.
  assign fifo_empty = (rptr == (wptr ^ (wptr >> 1)));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic clear_logs();
    grant_q.delete();
    burst_q.delete();
    rv_id_q.delete();
    addr_q.delete();
    rptr_q.delete();
    rd_cnt = 0;
    rv_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    wptr  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  // Monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd_en = 1'b0;
      prev_gnt   = '0;
      cur_burst  = 0;
    end else begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (rvalid) begin
        check("rvalid_after_rd_en", 32'(prev_rd_en), 32'd1);
        rv_id_q.push_back(int'(rvalid_id));
        addr_q.push_back(int'(rd_addr));
        rptr_q.push_back(int'(rptr));
        rv_cnt++;
      end
      if (gnt != 0 && prev_gnt == 0) begin
        grant_q.push_back(idx_of(gnt));
        cur_burst = 0;
      end
      if (rd_en) begin
        rd_cnt++;
        cur_burst++;
      end
      if (gnt == 0 && prev_gnt != 0) burst_q.push_back(cur_burst);
      prev_rd_en = rd_en;
      prev_gnt   = gnt;
    end
  end

  initial begin
    int exp_ids[10];
    int exp_addr[4];
    int exp_rptr[4];
    int exp_gnt[3];

    rst_n = 1'b0;
    req   = '0;
    wptr  = '0;
    clear_logs();

    // ---- Reset values, checked while reset is held ----
    #3;
    check("rst_gnt",       32'(gnt),       32'h0);
    check("rst_rd_en",     32'(rd_en),     32'h0);
    check("rst_rd_addr",   32'(rd_addr),   32'h0);
    check("rst_rptr",      32'(rptr),      32'h0);
    check("rst_rvalid",    32'(rvalid),    32'h0);
    check("rst_rvalid_id", 32'(rvalid_id), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);

    // ---- 1: three words, consumer 0 ----
    do_reset();
    wptr = 4'd3;
    req  = 4'b0001;
    step(1);
    check("t1_gnt_grant",  32'(gnt),   32'h1);
    check("t1_busy_grant", 32'(busy),  32'h1);
    check("t1_rd_en_grant",32'(rd_en), 32'h0);
    step(1);
    check("t1_rd_en_b0",   32'(rd_en),   32'h1);
    check("t1_addr_b0",    32'(rd_addr), 32'h0);
    step(1);
    check("t1_addr_b1",    32'(rd_addr), 32'h1);
    check("t1_rptr_b1",    32'(rptr),    32'h1);
    check("t1_rvalid_b1",  32'(rvalid),  32'h1);
    step(1);
    check("t1_addr_b2",    32'(rd_addr), 32'h2);
    check("t1_rptr_b2",    32'(rptr),    32'h3);
    step(1);
    check("t1_addr_b3",    32'(rd_addr), 32'h3);
    check("t1_rptr_b3",    32'(rptr),    32'h2);
    check("t1_empty",      32'(fifo_empty), 32'h1);
    check("t1_rd_en_empty",32'(rd_en),   32'h0);
    step(4);
    check("t1_busy_end",   32'(busy),    32'h0);
    check("t1_gnt_end",    32'(gnt),     32'h0);
    check("t1_rd_cnt",     32'(rd_cnt),  32'd3);
    check("t1_rv_cnt",     32'(rv_cnt),  32'd3);
    check("t1_nbursts",    32'(burst_q.size()), 32'd1);
    check("t1_burst_len",  32'(burst_q[0]), 32'd3);
    for (int i = 0; i < 3; i++) check("t1_rv_id", 32'(rv_id_q[i]), 32'd0);

    // ---- 2: ten words, consumers 0 and 2 alternate ----
    do_reset();
    wptr = 4'd10;
    req  = 4'b0101;
    step(30);
    exp_ids = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
    check("t2_ngrants",  32'(grant_q.size()), 32'd3);
    check("t2_grant0",   32'(grant_q[0]), 32'd0);
    check("t2_grant1",   32'(grant_q[1]), 32'd2);
    check("t2_grant2",   32'(grant_q[2]), 32'd0);
    check("t2_burst0",   32'(burst_q[0]), 32'd4);
    check("t2_burst1",   32'(burst_q[1]), 32'd4);
    check("t2_burst2",   32'(burst_q[2]), 32'd2);
    check("t2_rd_addr",  32'(rd_addr),    32'd10);
    check("t2_rv_cnt",   32'(rv_cnt),     32'd10);
    for (int i = 0; i < 10; i++) check("t2_rv_id", 32'(rv_id_q[i]), 32'(exp_ids[i]));
    req = '0;

    // ---- 3: consumer 1 drops req after two reads ----
    do_reset();
    wptr = 4'd5;
    req  = 4'b0010;
    step(4);
    req  = 4'b0000;
    step(4);
    check("t3_grant",   32'(grant_q[0]), 32'd1);
    check("t3_rd_cnt",  32'(rd_cnt),     32'd2);
    check("t3_rd_addr", 32'(rd_addr),    32'd2);
    check("t3_gnt",     32'(gnt),        32'h0);
    check("t3_busy",    32'(busy),       32'h0);

    // ---- 4: address wrap 14 -> 15,0,1,2 ----
    do_reset();
    wptr = 4'd14;
    req  = 4'b0001;
    step(40);
    check("t4_addr14",  32'(rd_addr), 32'd14);
    check("t4_rptr14",  32'(rptr),    32'h9);
    clear_logs();
    wptr = 4'd2;
    step(12);
    exp_addr = '{15, 0, 1, 2};
    exp_rptr = '{8, 0, 1, 3};
    check("t4_rd_cnt",  32'(rd_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_wrap_addr", 32'(addr_q[i]), 32'(exp_addr[i]));
      check("t4_wrap_rptr", 32'(rptr_q[i]), 32'(exp_rptr[i]));
    end
    req = '0;

    // ---- 5: asynchronous reset in the second read cycle ----
    do_reset();
    wptr = 4'd5;
    req  = 4'b0001;
    step(3);
    check("t5_rd_en_pre", 32'(rd_en), 32'h1);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("t5_rd_en",   32'(rd_en),   32'h0);
    check("t5_gnt",     32'(gnt),     32'h0);
    check("t5_rd_addr", 32'(rd_addr), 32'h0);
    check("t5_rptr",    32'(rptr),    32'h0);
    check("t5_rvalid",  32'(rvalid),  32'h0);
    check("t5_busy",    32'(busy),    32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    step(8);
    check("t5_no_rvalid", 32'(rv_cnt), 32'd0);
    check("t5_no_rd_en",  32'(rd_cnt), 32'd0);

    // ---- 6: consumers 1 and 3 with a deep FIFO ----
    do_reset();
    wptr = 4'd12;
    req  = 4'b1010;
    step(30);
`ifdef VFIFO_RD_FIXED_PRIO_EN
    exp_gnt = '{1, 1, 1};
`else
    exp_gnt = '{1, 3, 1};
`endif
    check("t6_ngrants", 32'(grant_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("t6_grant", 32'(grant_q[i]), 32'(exp_gnt[i]));
    check("t6_rd_addr", 32'(rd_addr), 32'd12);
    req = '0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
